// File: rtl/vliw_fetch.sv
// rtl/vliw_fetch.sv - VLIW bundle fetch: one-outstanding imem FSM, bundle FIFO, issue register.
// FETCH_PREFETCH_EN selects a 2-deep bundle FIFO; otherwise 1-deep, fetching only when empty.
module vliw_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_in,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [127:0] imem_rdata,
    output logic [31:0]  slot0_inst,
    output logic [31:0]  slot1_inst,
    output logic [31:0]  slot2_inst,
    output logic [31:0]  slot3_inst,
    output logic         issue_stall
);

`ifdef FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    localparam logic [1:0] FREQ  = 2'd0;
    localparam logic [1:0] FWAIT = 2'd1;
    localparam logic [1:0] FDROP = 2'd2;

    logic [1:0]   state;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic [127:0] fifo_q [0:1];
    logic [127:0] issue_q;
    logic         issue_valid;

    logic [31:0]  redirect_base;
    logic         fifo_full;
    logic         push;
    logic         pop;
    logic         wr_idx;
    logic         show;

    assign redirect_base = redirect_pc & 32'hFFFF_FFF0;
    assign fifo_full     = (count == DEPTH);

    // A redirect cycle never launches a request so the memory never sees a stale address accepted.
    assign imem_req  = (state == FREQ) && !fifo_full && !redirect_valid && !rst;
    assign imem_addr = pc;

    assign push   = (state == FWAIT) && imem_rvalid && !redirect_valid;
    assign pop    = !rst && !hold_in && !redirect_valid && (count != 2'd0);
    assign wr_idx = count[0] ^ pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREQ;
            pc    <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_base;
            case (state)
                // A response landing with the redirect is the outstanding one, so nothing is left to drop.
                FWAIT, FDROP: state <= imem_rvalid ? FREQ : FDROP;
                default:      state <= FREQ;
            endcase
        end else begin
            case (state)
                FREQ: begin
                    if (imem_req && imem_ready) begin
                        state <= FWAIT;
                        pc    <= pc + 32'd16;
                    end
                end
                FWAIT:   if (imem_rvalid) state <= FREQ;
                FDROP:   if (imem_rvalid) state <= FREQ;
                default: state <= FREQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            count       <= 2'd0;
            issue_valid <= 1'b0;
        end else begin
            if (!hold_in) begin
                issue_valid <= (count != 2'd0);
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            issue_q   <= fifo_q[0];
            fifo_q[0] <= fifo_q[1];
        end
        if (push) begin
            fifo_q[wr_idx] <= imem_rdata;
        end
    end

    assign show        = issue_valid && !rst;
    assign slot0_inst  = show ? issue_q[31:0]   : NOP_INST;
    assign slot1_inst  = show ? issue_q[63:32]  : NOP_INST;
    assign slot2_inst  = show ? issue_q[95:64]  : NOP_INST;
    assign slot3_inst  = show ? issue_q[127:96] : NOP_INST;
    assign issue_stall = hold_in || !show;

endmodule

// File: tb/tb_vliw_fetch.sv
// tb/tb_vliw_fetch.sv - randomized self-checking bench for vliw_fetch against an address-sequence model.
module tb_vliw_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hold_in = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc = 32'h0;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready = 1'b0;
    logic         imem_rvalid = 1'b0;
    logic [127:0] imem_rdata = 128'h0;
    logic [31:0]  slot0_inst, slot1_inst, slot2_inst, slot3_inst;
    logic         issue_stall;

    always #5 clk = ~clk;

    vliw_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .hold_in(hold_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .slot0_inst(slot0_inst), .slot1_inst(slot1_inst),
        .slot2_inst(slot2_inst), .slot3_inst(slot3_inst),
        .issue_stall(issue_stall)
    );

    int total = 0;
    int bad = 0;
    int mem_mode = 1;
    logic         pend_valid = 1'b0;
    logic [31:0]  pend_addr = 32'h0;
    int           pend_lat = 0;
    logic         inject_rv = 1'b0;
    logic [31:0]  exp_addr = RESET_PC;
    logic [127:0] prev_slots = 128'h0;
    logic [31:0]  acc_q[$];
    int           issued = 0;
    logic         last_req = 1'b0;
    logic [31:0]  last_req_addr = 32'h0;
    logic         prev_wait = 1'b0;
    logic [31:0]  prev_wait_addr = 32'h0;

    function automatic logic [127:0] bundle_of(input logic [31:0] a);
        logic [127:0] b;
        if (a == 32'h0) return {32'd4, 32'd3, 32'd2, 32'd1};
        for (int k = 0; k < 4; k++) b[32*k +: 32] = {a[31:4], 2'(k), 2'b11};
        return b;
    endfunction

    // One clock: drive at negedge, sample request, then check the issued slots after the edge.
    task automatic cycle(input logic hold, input logic redir, input logic [31:0] rpc);
        logic rv, req_s, acc, rst_s;
        logic [31:0] addr_s;
        logic [127:0] s;
        hold_in = hold;
        redirect_valid = redir;
        redirect_pc = rpc;
        rv = (pend_valid && pend_lat == 0) || inject_rv;
        imem_rvalid = rv;
        imem_rdata = inject_rv ? bundle_of(32'h5550) : bundle_of(pend_addr);
        imem_ready = (mem_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rst_s = rst;
        #1;
        req_s = imem_req;
        addr_s = imem_addr;
        acc = req_s && imem_ready;
        if (rst_s) begin
            total++;
            if (req_s !== 1'b0) begin
                bad++;
                $display("FAIL req_in_reset got=%b want=0", req_s);
            end
        end
        if (req_s) begin
            total++;
            if (addr_s[3:0] !== 4'h0 || (pend_valid && !rv)) begin
                bad++;
                $display("FAIL req_legal addr=%h outstanding=%b want aligned and none outstanding", addr_s, pend_valid);
            end
        end
        if (prev_wait && !redir && !rst_s) begin
            total++;
            if (req_s !== 1'b1 || addr_s !== prev_wait_addr) begin
                bad++;
                $display("FAIL req_stable got req=%b addr=%h want req=1 addr=%h", req_s, addr_s, prev_wait_addr);
            end
        end
        prev_wait = req_s && !imem_ready;
        prev_wait_addr = addr_s;
        last_req = req_s;
        last_req_addr = addr_s;
        @(posedge clk);
        #1;
        if (rst_s) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid && pend_lat == 0) pend_valid = 1'b0;
            else if (pend_valid) pend_lat--;
            if (acc) begin
                pend_valid = 1'b1;
                pend_addr = addr_s;
                pend_lat = (mem_mode == 0) ? int'($urandom_range(0, 3)) : ((mem_mode == 1) ? 0 : 3);
                acc_q.push_back(addr_s);
            end
        end
        s = {slot3_inst, slot2_inst, slot1_inst, slot0_inst};
        if (rst_s || redir) begin
            total++;
            if (s !== {4{NOP}}) begin
                bad++;
                $display("FAIL flush_nop got=%h want=%h", s, {4{NOP}});
            end
            exp_addr = rst_s ? RESET_PC : (rpc & 32'hFFFF_FFF0);
        end else if (hold) begin
            total++;
            if (s !== prev_slots) begin
                bad++;
                $display("FAIL hold_frozen got=%h want=%h", s, prev_slots);
            end
        end else if (s !== {4{NOP}}) begin
            total++;
            if (s !== bundle_of(exp_addr)) begin
                bad++;
                $display("FAIL issue_order got=%h want=%h", s, bundle_of(exp_addr));
            end
            exp_addr = exp_addr + 32'd16;
            issued++;
        end
        total++;
        if (issue_stall !== (hold_in | (s === {4{NOP}}))) begin
            bad++;
            $display("FAIL stall got=%b want=%b", issue_stall, hold_in | (s === {4{NOP}}));
        end
        prev_slots = s;
        inject_rv = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_mode = 1;
        cycle(0, 0, 32'h0);
        cycle(0, 0, 32'h0);
        rst = 1'b0;
        acc_q.delete();
        inject_rv = 1'b1;
        cycle(0, 0, 32'h0);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== RESET_PC) begin
            bad++;
            $display("FAIL first_req got_count=%0d want first addr=%h", acc_q.size(), RESET_PC);
        end
    endtask

    task automatic test_first_bundle();
        cycle(0, 0, 32'h0);
        total++;
        if (slot0_inst !== NOP) begin
            bad++;
            $display("FAIL no_bypass got=%h want=%h", slot0_inst, NOP);
        end
        cycle(0, 0, 32'h0);
        total++;
        if (slot0_inst !== 32'd1 || slot1_inst !== 32'd2 || slot2_inst !== 32'd3 ||
            slot3_inst !== 32'd4 || issue_stall !== 1'b0) begin
            bad++;
            $display("FAIL first_bundle got=%h %h %h %h stall=%b want=1 2 3 4 stall=0",
                     slot0_inst, slot1_inst, slot2_inst, slot3_inst, issue_stall);
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0);
        total++;
        if (acc_q.size() < 3 || acc_q[1] !== 32'h10 || acc_q[2] !== 32'h20) begin
            bad++;
            $display("FAIL addr_seq got_count=%0d want 0x10 then 0x20", acc_q.size());
        end
    endtask

    task automatic test_hold();
        int n;
        mem_mode = 1;
        cycle(1, 1, 32'h2000);
        n = acc_q.size();
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'h0);
        total++;
        if (acc_q.size() - n != DEPTH || last_req !== 1'b0) begin
            bad++;
            $display("FAIL hold_fill got=%0d req=%b want=%0d req=0", acc_q.size() - n, last_req, DEPTH);
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 32'h0);
        total++;
        if (exp_addr - 32'h2000 < 32'h20) begin
            bad++;
            $display("FAIL hold_release got next=%h want >= %h", exp_addr, 32'h2020);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        bit seen, non_nop;
        mem_mode = 2;
        cycle(0, 1, 32'h500);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            n = acc_q.size();
            cycle(0, 0, 32'h0);
            if (acc_q.size() > n) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_accept got=none want=accept within 20 cycles");
        end
        cycle(0, 1, 32'h1004);
        n = acc_q.size();
        seen = 0;
        non_nop = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(0, 0, 32'h0);
            if (slot0_inst !== NOP) non_nop = 1;
            if (acc_q.size() > n) seen = 1;
        end
        total++;
        if (!seen || acc_q[n] !== 32'h1000 || non_nop) begin
            bad++;
            $display("FAIL redirect_wait seen=%b addr=%h non_nop=%b want addr=00001000 non_nop=0",
                     seen, seen ? acc_q[n] : 32'h0, non_nop);
        end
    endtask

    task automatic test_redirect_rvalid();
        bit found;
        mem_mode = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend_valid && pend_lat == 0) begin
                cycle(0, 1, 32'h4008);
                found = 1;
            end else begin
                cycle(0, 0, 32'h0);
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rv_redirect_setup got=none want=response within 20 cycles");
        end
        cycle(0, 0, 32'h0);
        total++;
        if (last_req !== 1'b1 || last_req_addr !== 32'h4000) begin
            bad++;
            $display("FAIL rv_redirect got req=%b addr=%h want req=1 addr=00004000", last_req, last_req_addr);
        end
    endtask

    task automatic test_wrap();
        int n;
        mem_mode = 1;
        cycle(0, 1, 32'hFFFF_FFF0);
        n = acc_q.size();
        for (int i = 0; i < 8; i++) cycle(0, 0, 32'h0);
        total++;
        if (acc_q.size() < n + 2 || acc_q[n] !== 32'hFFFF_FFF0 || acc_q[n+1] !== 32'h0) begin
            bad++;
            $display("FAIL wrap got_count=%0d want FFFFFFF0 then 00000000", acc_q.size() - n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mem_mode = 1;
        cycle(1, 1, 32'h3000);
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'h0);
        rst = 1'b1;
        cycle(1, 0, 32'h0);
        total++;
        if (slot0_inst !== NOP || issue_stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got slot0=%h stall=%b want %h stall=1", slot0_inst, issue_stall, NOP);
        end
        rst = 1'b0;
        n = acc_q.size();
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0);
        total++;
        if (acc_q.size() <= n || acc_q[n] !== RESET_PC) begin
            bad++;
            $display("FAIL reset_mid_req got_count=%0d want first addr=%h", acc_q.size() - n, RESET_PC);
        end
    endtask

    task automatic test_random();
        int start;
        start = issued;
        mem_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0, $urandom);
        end
        total++;
        if (issued - start < 100) begin
            bad++;
            $display("FAIL random_progress got=%0d want>=100", issued - start);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_bundle();
        test_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
